ps2_mouse_init_ctrl: RTL and testbench

Sequencing controller that brings a PS/2 mouse from power-up into stream mode, then gates received bytes through to the mouse packet parser. It sits between the PS/2 byte transceiver and the parser. It issues the reset and enable-reporting commands, checks every device response, and retries on failure. It forwards device bytes downstream only once the mouse is streaming, so the parser never sees init-handshake bytes.

---
 rtl/ps2_mouse_init_ctrl_if.sv | 22 ++
 rtl/ps2_mouse_init_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_ps2_mouse_init_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_mouse_init_ctrl_if.sv
// Transceiver and parser side signals of the PS/2 mouse init controller.
// master = controller, slave = transceiver/parser/device side.
interface ps2_mouse_init_ctrl_if;
  logic [7:0] cmd_byte;
  logic       cmd_send;
  logic       cmd_sent;
  logic       cmd_error;
  logic [7:0] rx_byte;
  logic       rx_byte_en;
  logic [7:0] stream_byte;
  logic       stream_byte_en;

  modport master (
    output cmd_byte, cmd_send, stream_byte, stream_byte_en,
    input  cmd_sent, cmd_error, rx_byte, rx_byte_en
  );

  modport slave (
    input  cmd_byte, cmd_send, stream_byte, stream_byte_en,
    output cmd_sent, cmd_error, rx_byte, rx_byte_en
  );
endinterface

// File: rtl/ps2_mouse_init_ctrl.sv
// PS/2 mouse init sequencer (FF, [F3, rate], F4) with response checks, timeout and retry,
// then 1-cycle registered byte forwarding in stream mode. PS2_MOUSE_SET_RATE_EN adds the sample-rate step.
module ps2_mouse_init_ctrl #(
  parameter int         TIMEOUT_CYCLES = 25_000_000,
  parameter int         MAX_RETRIES    = 3,
  parameter logic [7:0] SAMPLE_RATE    = 8'd100
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        reinit,
  ps2_mouse_init_ctrl_if.master       bus,
  output logic                        ready,
  output logic                        fail,
  output logic [1:0]                  retry_cnt
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    RESET_CMD,
    TX_WAIT,
    ACK_WAIT,
    BAT_WAIT,
    ID_WAIT,
    RATE_CMD,
    RATE_VAL_CMD,
    EN_CMD,
    STREAM,
    FAIL
  } state_t;

  // Remembers which command is outstanding so ACK_WAIT knows where 0xFA leads.
  typedef enum logic [1:0] {
    STEP_RESET,
    STEP_RATE,
    STEP_RATE_VAL,
    STEP_EN
  } step_t;

  state_t          state_q, state_d;
  step_t           step_q, step_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [7:0]      cmd_byte_q, cmd_byte_d;
  logic            cmd_send_q, cmd_send_d;
  logic [7:0]      stream_byte_q, stream_byte_d;
  logic            stream_byte_en_q, stream_byte_en_d;
  logic [1:0]      retry_q, retry_d;

  logic            waiting;
  logic            timeout;
  logic            retry_req;

  assign waiting = (state_q == TX_WAIT) || (state_q == ACK_WAIT) ||
                   (state_q == BAT_WAIT) || (state_q == ID_WAIT);
  assign timeout = waiting && (timer_q == TIMER_LAST);

  always_comb begin
    state_d          = state_q;
    step_d           = step_q;
    cmd_byte_d       = cmd_byte_q;
    cmd_send_d       = 1'b0;
    stream_byte_d    = stream_byte_q;
    stream_byte_en_d = 1'b0;
    retry_d          = retry_q;
    retry_req        = 1'b0;

    case (state_q)
      RESET_CMD: begin
        cmd_byte_d = 8'hFF;
        cmd_send_d = 1'b1;
        step_d     = STEP_RESET;
        state_d    = TX_WAIT;
      end
      RATE_CMD: begin
        cmd_byte_d = 8'hF3;
        cmd_send_d = 1'b1;
        step_d     = STEP_RATE;
        state_d    = TX_WAIT;
      end
      RATE_VAL_CMD: begin
        cmd_byte_d = SAMPLE_RATE;
        cmd_send_d = 1'b1;
        step_d     = STEP_RATE_VAL;
        state_d    = TX_WAIT;
      end
      EN_CMD: begin
        cmd_byte_d = 8'hF4;
        cmd_send_d = 1'b1;
        step_d     = STEP_EN;
        state_d    = TX_WAIT;
      end
      TX_WAIT: begin
        // Device bytes are ignored here; an error outranks a same-cycle sent.
        if (bus.cmd_error)     retry_req = 1'b1;
        else if (bus.cmd_sent) state_d   = ACK_WAIT;
        else if (timeout)      retry_req = 1'b1;
      end
      ACK_WAIT: begin
        if (bus.rx_byte_en) begin
          if (bus.rx_byte == 8'hFA) begin
            case (step_q)
              STEP_RESET:    state_d = BAT_WAIT;
              STEP_RATE:     state_d = RATE_VAL_CMD;
              STEP_RATE_VAL: state_d = EN_CMD;
              default:       state_d = STREAM;
            endcase
          end else begin
            retry_req = 1'b1;
          end
        end else if (timeout) begin
          retry_req = 1'b1;
        end
      end
      BAT_WAIT: begin
        if (bus.rx_byte_en) begin
          if (bus.rx_byte == 8'hAA) state_d   = ID_WAIT;
          else                      retry_req = 1'b1;
        end else if (timeout) begin
          retry_req = 1'b1;
        end
      end
      ID_WAIT: begin
        if (bus.rx_byte_en) begin
          if (bus.rx_byte == 8'h00) begin
`ifdef PS2_MOUSE_SET_RATE_EN
            state_d = RATE_CMD;
`else
            state_d = EN_CMD;
`endif
          end else begin
            retry_req = 1'b1;
          end
        end else if (timeout) begin
          retry_req = 1'b1;
        end
      end
      STREAM: begin
        if (bus.rx_byte_en) begin
          stream_byte_d    = bus.rx_byte;
          stream_byte_en_d = 1'b1;
        end
      end
      default: begin
        // FAIL: parked until reinit or rst.
        state_d = FAIL;
      end
    endcase

    if (retry_req) begin
      if (int'(retry_q) < MAX_RETRIES) begin
        retry_d = retry_q + 2'd1;
        state_d = RESET_CMD;
      end else begin
        state_d = FAIL;
      end
    end

    if (reinit) begin
      state_d          = RESET_CMD;
      retry_d          = 2'd0;
      cmd_send_d       = 1'b0;
      stream_byte_d    = stream_byte_q;
      stream_byte_en_d = 1'b0;
    end

    // Restart the per-state wait timer on every state change; terminal count always forces one.
    if (!waiting || (state_d != state_q)) timer_d = '0;
    else                                  timer_d = timer_q + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= RESET_CMD;
      step_q           <= STEP_RESET;
      timer_q          <= '0;
      cmd_byte_q       <= 8'h00;
      cmd_send_q       <= 1'b0;
      stream_byte_q    <= 8'h00;
      stream_byte_en_q <= 1'b0;
      retry_q          <= 2'd0;
    end else begin
      state_q          <= state_d;
      step_q           <= step_d;
      timer_q          <= timer_d;
      cmd_byte_q       <= cmd_byte_d;
      cmd_send_q       <= cmd_send_d;
      stream_byte_q    <= stream_byte_d;
      stream_byte_en_q <= stream_byte_en_d;
      retry_q          <= retry_d;
    end
  end

  assign bus.cmd_byte       = cmd_byte_q;
  assign bus.cmd_send       = cmd_send_q;
  assign bus.stream_byte    = stream_byte_q;
  assign bus.stream_byte_en = stream_byte_en_q;
  assign ready              = (state_q == STREAM);
  assign fail               = (state_q == FAIL);
  assign retry_cnt          = retry_q;

endmodule

// File: tb/tb_ps2_mouse_init_ctrl.sv
// Directed bench for ps2_mouse_init_ctrl: init handshake, streaming, retries, timeout-to-FAIL, reinit/rst.
module tb_ps2_mouse_init_ctrl;
  localparam int TO = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       reinit = 1'b0;
  logic       ready;
  logic       fail;
  logic [1:0] retry_cnt;

  ps2_mouse_init_ctrl_if bus();

  ps2_mouse_init_ctrl #(
    .TIMEOUT_CYCLES(TO),
    .MAX_RETRIES(3),
    .SAMPLE_RATE(8'd100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .reinit(reinit),
    .bus(bus),
    .ready(ready),
    .fail(fail),
    .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         n_stream = 0;
  logic [7:0] sent_q[$];
  int         send_cyc[$];

  // Observe outputs just after each active edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (bus.cmd_send) begin
      sent_q.push_back(bus.cmd_byte);
      send_cyc.push_back(cyc);
    end
    if (bus.stream_byte_en) n_stream++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cmd(input string tag, input logic [7:0] b);
    for (int i = 0; i < 3 * TO; i++) begin
      if (bus.cmd_send) break;
      @(negedge clk);
    end
    chk({tag, "_send"}, 32'(bus.cmd_send), 32'h1);
    chk({tag, "_byte"}, 32'(bus.cmd_byte), 32'(b));
    tick();
  endtask

  task automatic pulse_sent(input string tag, input logic [7:0] b);
    chk({tag, "_hold"}, 32'(bus.cmd_byte), 32'(b));
    bus.cmd_sent = 1'b1;
    tick();
    bus.cmd_sent = 1'b0;
  endtask

  task automatic rx(input logic [7:0] b);
    bus.rx_byte    = b;
    bus.rx_byte_en = 1'b1;
    tick();
    bus.rx_byte_en = 1'b0;
  endtask

  task automatic do_cmd(input string tag, input logic [7:0] b);
    wait_cmd(tag, b);
    pulse_sent(tag, b);
  endtask

  task automatic finish_from_bat();
    rx(8'hAA);
    rx(8'h00);
`ifdef PS2_MOUSE_SET_RATE_EN
    do_cmd("f3", 8'hF3);
    rx(8'hFA);
    do_cmd("rate", 8'h64);
    rx(8'hFA);
`endif
    do_cmd("f4", 8'hF4);
    rx(8'hFA);
  endtask

  task automatic init_seq();
    do_cmd("ff", 8'hFF);
    rx(8'hFA);
    finish_from_bat();
  endtask

  task automatic stream_one(input logic [7:0] b);
    rx(b);
    chk("stream_en", 32'(bus.stream_byte_en), 32'h1);
    chk("stream_byte", 32'(bus.stream_byte), 32'(b));
    tick();
    chk("stream_en_drop", 32'(bus.stream_byte_en), 32'h0);
  endtask

  task automatic do_reinit();
    reinit = 1'b1;
    tick();
    reinit = 1'b0;
  endtask

  initial begin
    int exp_sends;
`ifdef PS2_MOUSE_SET_RATE_EN
    exp_sends = 4;
`else
    exp_sends = 2;
`endif
    bus.cmd_sent   = 1'b0;
    bus.cmd_error  = 1'b0;
    bus.rx_byte    = 8'h00;
    bus.rx_byte_en = 1'b0;

    // Reset values
    tick(3);
    chk("rst_cmd_byte", 32'(bus.cmd_byte), 32'h0);
    chk("rst_cmd_send", 32'(bus.cmd_send), 32'h0);
    chk("rst_stream_byte", 32'(bus.stream_byte), 32'h0);
    chk("rst_stream_en", 32'(bus.stream_byte_en), 32'h0);
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_fail", 32'(fail), 32'h0);
    chk("rst_retry", 32'(retry_cnt), 32'h0);

    // Nominal init: cmd_send on the first cycle after rst drops
    rst = 1'b0;
    tick();
    chk("first_send", 32'(bus.cmd_send), 32'h1);
    chk("first_byte", 32'(bus.cmd_byte), 32'hFF);
    init_seq();
    chk("nom_ready", 32'(ready), 32'h1);
    chk("nom_retry", 32'(retry_cnt), 32'h0);
    chk("nom_fail", 32'(fail), 32'h0);
    chk("nom_nsend", sent_q.size(), exp_sends);
    chk("nom_send0", 32'(sent_q[0]), 32'hFF);
    chk("nom_sendlast", 32'(sent_q[sent_q.size() - 1]), 32'hF4);
    chk("nom_no_stream", n_stream, 0);

    // Streaming
    stream_one(8'h08);
    stream_one(8'h05);
    stream_one(8'hFB);
    chk("stream_count", n_stream, 3);

    // rst mid-stream together with a byte
    rst = 1'b1;
    bus.rx_byte = 8'h77;
    bus.rx_byte_en = 1'b1;
    tick();
    bus.rx_byte_en = 1'b0;
    chk("rst_mid_en", 32'(bus.stream_byte_en), 32'h0);
    chk("rst_mid_ready", 32'(ready), 32'h0);
    rst = 1'b0;
    init_seq();
    chk("rst_mid_reinit_ready", 32'(ready), 32'h1);

    // reinit with a same-cycle byte in STREAM: byte dropped, FF follows
    bus.rx_byte = 8'h55;
    bus.rx_byte_en = 1'b1;
    do_reinit();
    bus.rx_byte_en = 1'b0;
    chk("reinit_drop", 32'(bus.stream_byte_en), 32'h0);
    chk("reinit_ready", 32'(ready), 32'h0);

    // 0xFE to the reset command
    wait_cmd("fe_ff", 8'hFF);
    pulse_sent("fe_ff", 8'hFF);
    rx(8'hFE);
    chk("fe_retry", 32'(retry_cnt), 32'h1);
    init_seq();
    chk("fe_ready", 32'(ready), 32'h1);
    chk("fe_retry_done", 32'(retry_cnt), 32'h1);

    // cmd_error on F4, FC in BAT_WAIT, byte at timeout terminal count
    do_reinit();
    chk("reinit_retry_clr", 32'(retry_cnt), 32'h0);
    wait_cmd("ce_ff", 8'hFF);
    rx(8'h12);
    pulse_sent("ce_ff", 8'hFF);
    rx(8'hFA);
    rx(8'hAA);
    rx(8'h00);
`ifdef PS2_MOUSE_SET_RATE_EN
    do_cmd("ce_f3", 8'hF3);
    rx(8'hFA);
    do_cmd("ce_rate", 8'h64);
    rx(8'hFA);
`endif
    wait_cmd("ce_f4", 8'hF4);
    chk("ce_tx_ignore", 32'(retry_cnt), 32'h0);
    bus.cmd_error = 1'b1;
    tick();
    bus.cmd_error = 1'b0;
    chk("ce_retry", 32'(retry_cnt), 32'h1);
    do_cmd("fc_ff", 8'hFF);
    rx(8'hFA);
    rx(8'hFC);
    chk("fc_retry", 32'(retry_cnt), 32'h2);
    do_cmd("tc_ff", 8'hFF);
    tick(TO - 1);
    rx(8'hFA);
    chk("tc_byte_wins", 32'(retry_cnt), 32'h2);
    finish_from_bat();
    chk("tc_ready", 32'(ready), 32'h1);

    // No response at all: four FF sends spaced by the timeout, then FAIL
    do_reinit();
    sent_q.delete();
    send_cyc.delete();
    for (int i = 0; i < 5 * TO + 100; i++) begin
      if (fail) break;
      tick();
    end
    chk("to_fail", 32'(fail), 32'h1);
    chk("to_ready", 32'(ready), 32'h0);
    chk("to_retry", 32'(retry_cnt), 32'h3);
    chk("to_nsend", sent_q.size(), 4);
    if (send_cyc.size() == 4) begin
      chk("to_gap1", send_cyc[1] - send_cyc[0], TO + 1);
      chk("to_gap3", send_cyc[3] - send_cyc[2], TO + 1);
      chk("to_byte3", 32'(sent_q[3]), 32'hFF);
    end
    tick(20);
    chk("fail_quiet", sent_q.size(), 4);
    chk("fail_hold", 32'(fail), 32'h1);
    do_reinit();
    chk("fail_reinit_retry", 32'(retry_cnt), 32'h0);
    chk("fail_reinit_fail", 32'(fail), 32'h0);
    wait_cmd("fail_reinit_ff", 8'hFF);

`ifdef PS2_MOUSE_SET_RATE_EN
    // Missing ACK after the sample-rate value
    pulse_sent("nr_ff", 8'hFF);
    rx(8'hFA);
    rx(8'hAA);
    rx(8'h00);
    do_cmd("nr_f3", 8'hF3);
    rx(8'hFA);
    do_cmd("nr_rate", 8'h64);
    wait_cmd("nr_restart", 8'hFF);
    chk("nr_retry", 32'(retry_cnt), 32'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
